// File: rtl/wb_burst_reader_pkg.sv
// Shared encodings for the Wishbone burst reader: cycle type and burst type
// codes, plus the controller state type.
package wb_burst_pkg;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_SPACE,
    BURST
  } state_t;
endpackage

// File: rtl/wb_burst_reader_if.sv
// Wishbone B4 bus bundle. clk and rst travel with the bus so that master and
// slave share them.
interface wshb_if (
  input logic clk,
  input logic rst
);
  logic [31:0] adr;
  logic [31:0] dat_ms;
  logic [31:0] dat_sm;
  logic [3:0]  sel;
  logic        we;
  logic        cyc;
  logic        stb;
  logic [2:0]  cti;
  logic [1:0]  bte;
  logic        ack;
  logic        err;
  logic        rty;

  modport master (
    input  clk, rst, dat_sm, ack, err, rty,
    output adr, dat_ms, sel, we, cyc, stb, cti, bte
  );

  modport slave (
    input  clk, rst, adr, dat_ms, sel, we, cyc, stb, cti, bte,
    output dat_sm, ack, err, rty
  );
endinterface

// File: rtl/wb_burst_reader_sync_fifo.sv
// Single-clock FIFO with a synchronous active-high reset. The head word is
// read straight from storage, so a word pushed on one edge is visible right after it.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/wb_burst_reader.sv
// Wishbone read engine: streams nb_words words from base_adr into a
// valid/ready stream, opening a burst only when the FIFO can hold all of it.
//
// state      | meaning
// IDLE       | waiting for start
// WAIT_SPACE | sizing next burst, waiting for FIFO room
// BURST      | cyc/stb high, one word per ack
module wb_burst_reader
  import wb_burst_pkg::*;
#(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 16
) (
  wshb_if.master           wb_m,
  input  logic             start,
  input  logic [31:0]      base_adr,
  input  logic [LEN_W-1:0] nb_words,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready
);
  localparam int BEAT_W = $clog2(BURST_LEN) + 1;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  state_t            state;
  logic [31:0]       adr_cur;
  logic [31:0]       adr_q;
  logic [LEN_W-1:0]  remaining;
  logic [BEAT_W-1:0] beat_cnt;
  logic [BEAT_W-1:0] beats;
  logic              cyc_q;
  logic [3:0]        sel_q;
  logic [2:0]        cti_q;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  free_slots;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;

  assign beats      = (remaining < LEN_W'(BURST_LEN)) ? remaining[BEAT_W-1:0] : BEAT_W'(BURST_LEN);
  assign free_slots = CNT_W'(FIFO_DEPTH) - fifo_count;
  assign push       = cyc_q && wb_m.ack && !wb_m.err && !fifo_full;
  assign pop        = out_valid && out_ready;
  assign out_valid  = !fifo_empty;

  assign wb_m.adr    = adr_q;
  assign wb_m.dat_ms = '0;
  assign wb_m.sel    = sel_q;
  assign wb_m.we     = 1'b0;
  assign wb_m.cyc    = cyc_q;
  assign wb_m.stb    = cyc_q;
  assign wb_m.cti    = cti_q;
  assign wb_m.bte    = BTE_LINEAR;

  always_ff @(posedge wb_m.clk) begin
    if (wb_m.rst) begin
      state     <= IDLE;
      adr_cur   <= '0;
      adr_q     <= '0;
      remaining <= '0;
      beat_cnt  <= '0;
      cyc_q     <= 1'b0;
      sel_q     <= 4'h0;
      cti_q     <= CTI_CLASSIC;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (nb_words == '0) begin
              done <= 1'b1;
            end else begin
              adr_cur   <= base_adr & 32'hFFFF_FFFC;
              remaining <= nb_words;
              error     <= 1'b0;
              busy      <= 1'b1;
              state     <= WAIT_SPACE;
            end
          end
        end
        WAIT_SPACE: begin
          if (free_slots >= CNT_W'(beats)) begin
            beat_cnt <= beats;
            adr_q    <= adr_cur;
            cyc_q    <= 1'b1;
            sel_q    <= 4'hF;
            cti_q    <= (beats == BEAT_W'(1)) ? CTI_EOB : CTI_INCR;
            state    <= BURST;
          end
        end
        BURST: begin
          if (wb_m.err) begin
            cyc_q <= 1'b0;
            sel_q <= 4'h0;
            cti_q <= CTI_CLASSIC;
            error <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (wb_m.ack) begin
            adr_cur   <= adr_cur + 32'd4;
            remaining <= remaining - 1'b1;
            beat_cnt  <= beat_cnt - 1'b1;
            if (beat_cnt == BEAT_W'(1)) begin
              cyc_q <= 1'b0;
              sel_q <= 4'h0;
              cti_q <= CTI_CLASSIC;
              if (remaining == LEN_W'(1)) begin
                done  <= 1'b1;
                busy  <= 1'b0;
                state <= IDLE;
              end else begin
                state <= WAIT_SPACE;
              end
            end else begin
              // cti is registered, so the end-of-burst code is set one beat early
              adr_q <= adr_cur + 32'd4;
              if (beat_cnt == BEAT_W'(2)) cti_q <= CTI_EOB;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  sync_fifo #(
    .WIDTH(32),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (wb_m.clk),
    .rst  (wb_m.rst),
    .push (push),
    .pop  (pop),
    .din  (wb_m.dat_sm),
    .dout (out_data),
    .full (fifo_full),
    .empty(fifo_empty),
    .count(fifo_count)
  );
endmodule
